// File: rtl/urv_divide_if.sv
// rtl/urv_divide_if.sv - execute-stage handshake bundle for the iterative divider
//
// Groups the operand, control and result signals that pass between execute
// and urv_divide. Signal names keep the core's _i/_o suffixes as seen from
// the divider.
//   master : execute side; drives stall/start/kill/operands, reads results
//   slave  : divider side; reads stall/start/kill/operands, drives results
// Parameter DIV_FUN_W is the width of the funct3 field d_fun_i.
interface urv_divide_if #(
    parameter int DIV_FUN_W = 3
);
    logic                 x_stall_i;
    logic                 start_i;
    logic                 kill_i;
    logic [31:0]          d_rs1_i;
    logic [31:0]          d_rs2_i;
    logic [DIV_FUN_W-1:0] d_fun_i;
    logic                 busy_o;
    logic                 done_o;
    logic [31:0]          q_o;

    modport master (
        output x_stall_i, start_i, kill_i, d_rs1_i, d_rs2_i, d_fun_i,
        input  busy_o, done_o, q_o
    );

    modport slave (
        input  x_stall_i, start_i, kill_i, d_rs1_i, d_rs2_i, d_fun_i,
        output busy_o, done_o, q_o
    );
endinterface

// File: rtl/urv_divide.sv
// rtl/urv_divide.sv - iterative 32-bit RV32M DIV/DIVU/REM/REMU divider
//
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : urv_divide_if.slave (stall, start, kill, rs1, rs2, funct3 in;
//           busy, done, q out)
// Restoring division, one quotient bit per cycle:
//   IDLE -> PREP -> ITER x32 -> FIX -> DONE
// Optional build macro URV_DIV_EARLY_OUT_EN: divide-by-zero and signed
// overflow finish straight from IDLE/DONE into DONE without raising busy.
module urv_divide (
    input  logic         clk_i,
    input  logic         rst_i,
    urv_divide_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_a;       // dividend, becomes the quotient as bits shift in
    logic [31:0] r_b;       // divisor
    logic [31:0] r_r;       // partial remainder
    logic [31:0] r_rs1;     // original dividend, needed for the div-by-zero remainder
    logic        r_signed;
    logic        r_rem;
    logic        r_div0;
    logic        r_ovf;
    logic        r_sign_q;
    logic        r_sign_r;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_q;

    logic        w_signed_in;
    logic        w_div0_in;
    logic        w_ovf_in;
    logic [32:0] w_shift;
    logic [32:0] w_sub;
    logic        w_ge;
    logic [31:0] w_quo;
    logic [31:0] w_remd;
    logic [31:0] w_fix_res;

    assign w_signed_in = ~bus.d_fun_i[0];
    assign w_div0_in   = (bus.d_rs2_i == 32'd0);
    assign w_ovf_in    = w_signed_in && (bus.d_rs1_i == 32'h8000_0000)
                                     && (bus.d_rs2_i == 32'hFFFF_FFFF);

`ifdef URV_DIV_EARLY_OUT_EN
    logic [31:0] w_early_res;
    assign w_early_res = bus.d_fun_i[1] ? (w_div0_in ? bus.d_rs1_i : 32'd0)
                                        : (w_div0_in ? 32'hFFFF_FFFF : 32'h8000_0000);
`endif

    // A 33-bit compare is needed: once r[31] is set the shifted value
    // exceeds any 32-bit divisor.
    assign w_shift = {r_r, r_a[31]};
    assign w_ge    = (w_shift >= {1'b0, r_b});
    assign w_sub   = w_shift - {1'b0, r_b};

    always_comb begin
        w_quo  = (r_signed && r_sign_q) ? -r_a : r_a;
        w_remd = (r_signed && r_sign_r) ? -r_r : r_r;
        if (r_div0) begin
            w_quo  = 32'hFFFF_FFFF;
            w_remd = r_rs1;
        end else if (r_ovf) begin
            w_quo  = 32'h8000_0000;
            w_remd = 32'd0;
        end
        w_fix_res = r_rem ? w_remd : w_quo;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_r      <= 32'd0;
            r_rs1    <= 32'd0;
            r_signed <= 1'b0;
            r_rem    <= 1'b0;
            r_div0   <= 1'b0;
            r_ovf    <= 1'b0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_q      <= 32'd0;
        end else if (bus.kill_i) begin
            // Kill wins over stall and start; the result register is left alone.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (!bus.x_stall_i) begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    if (bus.start_i) begin
                        r_a      <= bus.d_rs1_i;
                        r_b      <= bus.d_rs2_i;
                        r_rs1    <= bus.d_rs1_i;
                        r_signed <= w_signed_in;
                        r_rem    <= bus.d_fun_i[1];
                        r_div0   <= w_div0_in;
                        r_ovf    <= w_ovf_in;
`ifdef URV_DIV_EARLY_OUT_EN
                        if (w_div0_in || w_ovf_in) begin
                            r_q     <= w_early_res;
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else
`endif
                        begin
                            r_state <= S_PREP;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_PREP: begin
                    r_sign_q <= r_a[31] ^ r_b[31];
                    r_sign_r <= r_a[31];
                    r_a      <= (r_signed && r_a[31]) ? -r_a : r_a;
                    r_b      <= (r_signed && r_b[31]) ? -r_b : r_b;
                    r_r      <= 32'd0;
                    r_cnt    <= 5'd31;
                    r_state  <= S_ITER;
                end
                S_ITER: begin
                    r_r <= w_ge ? w_sub[31:0] : w_shift[31:0];
                    r_a <= {r_a[30:0], w_ge};
                    if (r_cnt == 5'd0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                S_FIX: begin
                    r_q     <= w_fix_res;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o = r_busy;
    assign bus.done_o = r_done;
    assign bus.q_o    = r_q;

endmodule
